// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Package     : camera_pkg
// Description : Shared definitions for the OV7670 windowed capture path:
//               default sensor geometry, pixel-mode encodings, capture FSM
//               state encodings and the grayscale-to-RGB565 expansion helper.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

   // Default OV7670 VGA geometry
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   // Pixel mode encodings (value of the mode input)
   localparam logic MODE_RGB565 = 1'b0;
   localparam logic MODE_GRAY   = 1'b1;

   // Capture FSM state encodings
   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t SYNC   = 2'd1;
   localparam state_t ACTIVE = 2'd2;
   localparam state_t SKIP   = 2'd3;

   // Replicate an 8-bit luma sample into all three RGB565 channels
   function automatic logic [15:0] gray_to_565(input logic [7:0] i_y);
      return {i_y[7:3], i_y[7:2], i_y[7:3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : cam_sync_edge
// Description : Registers the OV7670 bus (vsync, href, data byte) once and
//               derives single-cycle edge pulses from the registered values.
// Ports       : i_clk        pixel clock
//               i_rst_n      asynchronous active-low reset
//               i_vsync      raw frame sync
//               i_href       raw line valid
//               i_data       raw data byte
//               o_href       registered line valid
//               o_data       registered data byte
//               o_vsync_rise registered vsync rising edge pulse
//               o_vsync_fall registered vsync falling edge pulse
//               o_href_fall  registered href falling edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cam_sync_edge (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_vsync,
   input  logic       i_href,
   input  logic [7:0] i_data,
   output logic       o_href,
   output logic [7:0] o_data,
   output logic       o_vsync_rise,
   output logic       o_vsync_fall,
   output logic       o_href_fall
);

   logic       r_vsync;
   logic       r_vsync_d;
   logic       r_href;
   logic       r_href_d;
   logic [7:0] r_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vsync   <= 1'b0;
         r_vsync_d <= 1'b0;
         r_href    <= 1'b0;
         r_href_d  <= 1'b0;
         r_data    <= 8'd0;
      end else begin
         r_vsync   <= i_vsync;
         r_vsync_d <= r_vsync;
         r_href    <= i_href;
         r_href_d  <= r_href;
         r_data    <= i_data;
      end
   end

   assign o_href       = r_href;
   assign o_data       = r_data;
   assign o_vsync_rise =  r_vsync & ~r_vsync_d;
   assign o_vsync_fall = ~r_vsync &  r_vsync_d;
   assign o_href_fall  = ~r_href  &  r_href_d;

endmodule
`default_nettype wire

// File: rtl/camera_capture_win.sv
`default_nettype none
// ============================================================================
// Module      : camera_capture_win
// Description : OV7670 byte-pair capture with compile-time crop window and
//               power-of-two decimation. Builds RGB565 or replicated-Y
//               grayscale pixels, emits dense frame-buffer write addresses,
//               a frame-done strobe and a sticky per-frame error flag.
// Ports       : p_clock     pixel clock (rising edge)
//               rst_n       asynchronous active-low reset
//               enable      capture enable, latched at frame start
//               mode        0 = RGB565, 1 = grayscale, latched at frame start
//               vsync/href  sensor frame/line sync
//               p_data      sensor data byte
//               pixel_data  assembled pixel
//               pixel_valid one-cycle strobe qualifying pixel_data/wraddr
//               wraddr      frame-buffer write address
//               frame_done  one-cycle end-of-frame strobe
//               frame_err   sticky line/frame geometry error
// Revision    : 1.0 - initial release
// ============================================================================
module camera_capture_win
   import camera_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int X0       = 0,
   parameter int Y0       = 0,
   parameter int WIN_W    = 640,
   parameter int WIN_H    = 480,
   parameter int DECIM    = 1,
   parameter int ADDR_W   = 19
) (
   input  logic              p_clock,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              mode,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        p_data,
   output logic [15:0]       pixel_data,
   output logic              pixel_valid,
   output logic [ADDR_W-1:0] wraddr,
   output logic              frame_done,
   output logic              frame_err
);

   // x counts up to H_ACTIVE inclusive; y needs room to see V_ACTIVE+1
   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 2);

   localparam logic [XW-1:0] X_LO    = XW'(X0);
   localparam logic [XW-1:0] X_WIN   = XW'(WIN_W);
   localparam logic [XW-1:0] X_DMASK = XW'(DECIM - 1);
   localparam logic [XW-1:0] H_MAX   = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_LO    = YW'(Y0);
   localparam logic [YW-1:0] Y_WIN   = YW'(WIN_H);
   localparam logic [YW-1:0] Y_DMASK = YW'(DECIM - 1);
   localparam logic [YW-1:0] V_MAX   = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_SAT   = {YW{1'b1}};

   // ------------------------------------------------------------------
   // Bus registration and edge detection
   // ------------------------------------------------------------------
   logic       w_href;
   logic [7:0] w_data;
   logic       w_vs_rise;
   logic       w_vs_fall;
   logic       w_href_fall;

   cam_sync_edge u_sync (
      .i_clk        (p_clock),
      .i_rst_n      (rst_n),
      .i_vsync      (vsync),
      .i_href       (href),
      .i_data       (p_data),
      .o_href       (w_href),
      .o_data       (w_data),
      .o_vsync_rise (w_vs_rise),
      .o_vsync_fall (w_vs_fall),
      .o_href_fall  (w_href_fall)
   );

   // ------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------
   state_t r_state;
   state_t w_state_nxt;
   logic   r_en;
   logic   r_mode;

   always_ff @(posedge p_clock or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_vs_rise) w_state_nxt = SYNC;
         SYNC:    if (w_vs_fall) w_state_nxt = r_en ? ACTIVE : SKIP;
         ACTIVE:  if (w_vs_rise) w_state_nxt = SYNC;
         SKIP:    if (w_vs_rise) w_state_nxt = SYNC;
         default: w_state_nxt = IDLE;
      endcase
   end

   logic w_in_sync;
   logic w_byte_en;
   logic w_line_end;
   logic w_frame_end;

   // A byte arriving with the vsync rise is dropped so the last pixel strobe
   // always precedes frame_done by at least one cycle.
   always_comb begin
      w_in_sync   = 1'b0;
      w_byte_en   = 1'b0;
      w_line_end  = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         SYNC:   w_in_sync = 1'b1;
         ACTIVE: begin
            w_byte_en   = w_href & ~w_vs_rise;
            w_line_end  = w_href_fall;
            w_frame_end = w_vs_rise;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Window, decimation and address datapath
   // ------------------------------------------------------------------
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic              r_phase;
   logic [7:0]        r_hi;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_pixel_data;
   logic              r_pixel_valid;
   logic [ADDR_W-1:0] r_wraddr;
   logic              r_frame_done;
   logic              r_frame_err;

   // Offsets from the window origin carry an extra borrow bit so "before the
   // window" is detected without comparing against a constant lower bound.
   logic [XW:0]       w_x_rel;
   logic [YW:0]       w_y_rel;
   logic              w_x_keep;
   logic              w_y_keep;
   logic              w_keep;
   logic              w_line_ok;
   logic              w_x_ok;
   logic              w_line_err;
   logic [YW-1:0]     w_y_next;
   logic [YW-1:0]     w_y_end;
   logic [15:0]       w_pixel;
   logic [ADDR_W-1:0] w_addr_next;

   always_comb begin
      w_x_rel     = {1'b0, r_x} - {1'b0, X_LO};
      w_y_rel     = {1'b0, r_y} - {1'b0, Y_LO};
      w_x_keep    = ~w_x_rel[XW] && (w_x_rel[XW-1:0] < X_WIN) &&
                    ((w_x_rel[XW-1:0] & X_DMASK) == '0);
      w_y_keep    = ~w_y_rel[YW] && (w_y_rel[YW-1:0] < Y_WIN) &&
                    ((w_y_rel[YW-1:0] & Y_DMASK) == '0);
      w_keep      = w_x_keep & w_y_keep;
      w_line_ok   = (r_y < V_MAX);
      w_x_ok      = (r_x < H_MAX);
      // Wrong length, dangling hi byte, or a line past the frame bottom
      w_line_err  = (r_x != H_MAX) | r_phase | ~w_line_ok;
      w_y_next    = (r_y == Y_SAT) ? r_y : r_y + YW'(1);
      w_y_end     = w_line_end ? w_y_next : r_y;
      w_pixel     = (r_mode == MODE_GRAY) ? gray_to_565(r_hi) : {r_hi, w_data};
      w_addr_next = (r_addr == {ADDR_W{1'b1}}) ? r_addr : r_addr + ADDR_W'(1);
   end

   always_ff @(posedge p_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_en          <= 1'b0;
         r_mode        <= MODE_RGB565;
         r_x           <= '0;
         r_y           <= '0;
         r_phase       <= 1'b0;
         r_hi          <= 8'd0;
         r_addr        <= '0;
         r_pixel_data  <= 16'd0;
         r_pixel_valid <= 1'b0;
         r_wraddr      <= '0;
         r_frame_done  <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_pixel_valid <= 1'b0;
         r_frame_done  <= 1'b0;

         if (w_in_sync) begin
            r_en        <= enable;
            r_mode      <= mode;
            r_x         <= '0;
            r_y         <= '0;
            r_phase     <= 1'b0;
            r_addr      <= '0;
            r_wraddr    <= '0;
            r_frame_err <= 1'b0;
         end

         if (w_byte_en) begin
            if (!w_line_ok || !w_x_ok) begin
               r_frame_err <= 1'b1;
            end else if (!r_phase) begin
               r_hi    <= w_data;
               r_phase <= 1'b1;
            end else begin
               r_phase <= 1'b0;
               r_x     <= r_x + XW'(1);
               if (w_keep) begin
                  r_pixel_data  <= w_pixel;
                  r_pixel_valid <= 1'b1;
                  r_wraddr      <= r_addr;
                  r_addr        <= w_addr_next;
               end
            end
         end

         if (w_line_end) begin
            r_x     <= '0;
            r_phase <= 1'b0;
            r_y     <= w_y_next;
            if (w_line_err) r_frame_err <= 1'b1;
         end

         // Line-end result is folded in first via w_y_end / w_line_err
         if (w_frame_end) begin
            r_frame_done <= 1'b1;
            if ((w_line_end & w_line_err) | (w_y_end != V_MAX)) r_frame_err <= 1'b1;
         end
      end
   end

   assign pixel_data  = r_pixel_data;
   assign pixel_valid = r_pixel_valid;
   assign wraddr      = r_wraddr;
   assign frame_done  = r_frame_done;
   assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_camera_capture_win.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_capture_win
// Description : Self-checking bench for camera_capture_win. Two instances
//               share one small sensor bus: a full-frame DECIM=1 instance and
//               a cropped DECIM=2 instance. Expected pixels/addresses are
//               queued as bytes are driven and popped on pixel_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_camera_capture_win;
   import camera_pkg::*;

   localparam int H   = 48;
   localparam int V   = 12;
   localparam int BX0 = 16;
   localparam int BY0 = 8;
   localparam int BW  = 32;
   localparam int BH  = 4;
   localparam int BD  = 2;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       enable  = 1'b0;
   logic       mode    = 1'b0;
   logic       vsync   = 1'b0;
   logic       href    = 1'b0;
   logic [7:0] p_data  = 8'd0;

   logic [15:0] pd_a, pd_b;
   logic        pv_a, pv_b, fd_a, fd_b, fe_a, fe_b;
   logic [9:0]  wa_a;
   logic [4:0]  wa_b;

   always #5 clk = ~clk;

   camera_capture_win #(
      .H_ACTIVE(H), .V_ACTIVE(V), .X0(0), .Y0(0), .WIN_W(H), .WIN_H(V),
      .DECIM(1), .ADDR_W(10)
   ) dut_a (
      .p_clock(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .vsync(vsync), .href(href), .p_data(p_data),
      .pixel_data(pd_a), .pixel_valid(pv_a), .wraddr(wa_a),
      .frame_done(fd_a), .frame_err(fe_a)
   );

   camera_capture_win #(
      .H_ACTIVE(H), .V_ACTIVE(V), .X0(BX0), .Y0(BY0), .WIN_W(BW), .WIN_H(BH),
      .DECIM(BD), .ADDR_W(5)
   ) dut_b (
      .p_clock(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .vsync(vsync), .href(href), .p_data(p_data),
      .pixel_data(pd_b), .pixel_valid(pv_b), .wraddr(wa_b),
      .frame_done(fd_b), .frame_err(fe_b)
   );

   typedef struct packed {
      logic [15:0] d;
      logic [9:0]  a;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int total = 0;
   int bad   = 0;

   int   n_push_a = 0, n_push_b = 0, n_val_a = 0, n_val_b = 0;
   int   addr_a = 0, addr_b = 0;
   int   done_a = 0, done_b = 0;
   logic err_done_a = 1'b0, err_done_b = 1'b0;
   logic cap_cur = 1'b0, gray_cur = 1'b0;
   logic [15:0] first_a0 = 16'd0, first_a1 = 16'd0, first_b0 = 16'd0;
   logic [9:0]  last_wa_a = 10'd0;
   logic [4:0]  last_wa_b = 5'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumers
   always @(negedge clk) begin
      exp_t e;
      if (pv_a === 1'b1) begin
         if (n_val_a == 0) first_a0 = pd_a;
         if (n_val_a == 1) first_a1 = pd_a;
         n_val_a++;
         last_wa_a = wa_a;
         check("a_pixel_expected", 32'(q_a.size() != 0), 32'd1);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("a_pixel_data", 32'(pd_a), 32'(e.d));
            check("a_wraddr", 32'(wa_a), 32'(e.a));
         end
      end
      if (pv_b === 1'b1) begin
         if (n_val_b == 0) first_b0 = pd_b;
         n_val_b++;
         last_wa_b = wa_b;
         check("b_pixel_expected", 32'(q_b.size() != 0), 32'd1);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("b_pixel_data", 32'(pd_b), 32'(e.d));
            check("b_wraddr", 32'(wa_b), 32'(e.a));
         end
      end
      if (fd_a === 1'b1) begin
         done_a++;
         err_done_a = fe_a;
         check("a_done_without_pixel", 32'(pv_a), 32'd0);
      end
      if (fd_b === 1'b1) begin
         done_b++;
         err_done_b = fe_b;
         check("b_done_without_pixel", 32'(pv_b), 32'd0);
      end
   end

   // Ends the current frame with a vsync pulse and checks its outcome
   task automatic vs_pulse(input logic exp_err);
      logic exp_done;
      int   d_a0, d_b0;
      exp_done = cap_cur;
      d_a0     = done_a;
      d_b0     = done_b;
      check("a_drained", 32'(q_a.size()), 32'd0);
      check("b_drained", 32'(q_b.size()), 32'd0);
      check("a_strobe_count", 32'(n_val_a), 32'(n_push_a));
      check("b_strobe_count", 32'(n_val_b), 32'(n_push_b));
      vsync = 1'b1;
      repeat (6) tick();
      vsync = 1'b0;
      repeat (6) tick();
      check("a_frame_done_count", 32'(done_a - d_a0), 32'(exp_done));
      check("b_frame_done_count", 32'(done_b - d_b0), 32'(exp_done));
      if (exp_done) begin
         check("a_frame_err", 32'(err_done_a), 32'(exp_err));
         check("b_frame_err", 32'(err_done_b), 32'(exp_err));
      end
      cap_cur  = enable;
      gray_cur = mode;
      n_push_a = 0; n_push_b = 0; n_val_a = 0; n_val_b = 0;
      addr_a   = 0; addr_b   = 0;
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_pixel_data_a", 32'(pd_a), 32'd0);
      check("rst_pixel_valid_a", 32'(pv_a), 32'd0);
      check("rst_wraddr_a", 32'(wa_a), 32'd0);
      check("rst_frame_err_a", 32'(fe_a), 32'd0);
      check("rst_pixel_data_b", 32'(pd_b), 32'd0);
      q_a.delete();
      q_b.delete();
      n_push_a = n_val_a;
      n_push_b = n_val_b;
      cap_cur  = 1'b0;
   endtask

   task automatic send_line(input int y, input int nbytes, input logic [7:0] base,
                            input int rst_at);
      logic [7:0]  b, hi;
      logic [15:0] pix;
      int          g, x;
      exp_t        e;
      hi = 8'd0;
      for (int k = 0; k < nbytes; k++) begin
         g      = y * 2 * H + k;
         b      = (g == 0) ? 8'hFF : 8'(32'(base) + g);
         href   = 1'b1;
         p_data = b;
         if (k == rst_at) begin
            check("pre_rst_pixel_nonzero", 32'(pd_a != 16'd0), 32'd1);
            mid_reset();
         end
         if (k == rst_at + 10) #2 rst_n = 1'b1;
         if (k % 2 == 0) begin
            hi = b;
         end else if (cap_cur && k < 2 * H && y < V) begin
            x   = k / 2;
            pix = gray_cur ? {hi[7:3], hi[7:2], hi[7:3]} : {hi, b};
            e.d = pix;
            e.a = 10'(addr_a);
            q_a.push_back(e);
            addr_a++;
            n_push_a++;
            if (x >= BX0 && x < BX0 + BW && y >= BY0 && y < BY0 + BH &&
                ((x - BX0) % BD) == 0 && ((y - BY0) % BD) == 0) begin
               e.a = 10'(addr_b);
               q_b.push_back(e);
               addr_b++;
               n_push_b++;
            end
         end
         tick();
      end
      href   = 1'b0;
      p_data = 8'd0;
      repeat (8) tick();
   endtask

   task automatic send_frame(input int nlines, input int short_line, input logic [7:0] base,
                             input int rst_line);
      for (int y = 0; y < nlines; y++)
         send_line(y, (y == short_line) ? 2 * H - 1 : 2 * H, base,
                   (y == rst_line) ? 41 : -100);
   endtask

   initial begin
      repeat (3) tick();
      check("reset_pixel_data", 32'(pd_a), 32'd0);
      check("reset_pixel_valid", 32'(pv_a), 32'd0);
      check("reset_wraddr", 32'(wa_a), 32'd0);
      check("reset_frame_done", 32'(fd_a), 32'd0);
      check("reset_frame_err", 32'(fe_a), 32'd0);
      check("reset_pixel_valid_b", 32'(pv_b), 32'd0);
      rst_n = 1'b1;
      tick();

      // First vsync after reset only arms capture
      enable = 1'b1;
      mode   = MODE_RGB565;
      vs_pulse(1'b0);

      // Full RGB565 frame
      send_frame(V, -1, 8'h87, -1);
      check("rgb_first_pixel", 32'(first_a0), 32'h0000FF88);
      check("rgb_second_pixel", 32'(first_a1), 32'h0000898A);
      check("rgb_pixel_total", 32'(n_val_a), 32'(H * V));
      check("rgb_last_wraddr", 32'(last_wa_a), 32'(H * V - 1));
      check("win_first_pixel", 32'(first_b0), 32'h0000A7A8);
      check("win_pixel_total", 32'(n_val_b), 32'd32);
      check("win_last_wraddr", 32'(last_wa_b), 32'd31);

      // Grayscale frame
      mode = MODE_GRAY;
      vs_pulse(1'b0);
      send_frame(V, -1, 8'h7E, -1);
      check("gray_ff", 32'(first_a0), 32'h0000FFFF);
      check("gray_80", 32'(first_a1), 32'h00008410);

      // Short line
      mode = MODE_RGB565;
      vs_pulse(1'b0);
      send_frame(V, 3, 8'h87, -1);
      vs_pulse(1'b1);

      // Missing last line
      send_frame(V - 1, -1, 8'h87, -1);
      vs_pulse(1'b1);

      // Good frame clears the error; then disable for the next frame
      send_frame(V, -1, 8'h33, -1);
      enable = 1'b0;
      vs_pulse(1'b0);

      // Disabled frame with enable raised mid-frame
      for (int y = 0; y < V; y++) begin
         if (y == 6) enable = 1'b1;
         send_line(y, 2 * H, 8'h55, -100);
      end
      vs_pulse(1'b0);

      // Reset in the middle of line 2, remainder of the frame is dropped
      send_frame(V, -1, 8'h87, 2);
      vs_pulse(1'b0);

      // Capture resumes
      send_frame(V, -1, 8'h11, -1);
      vs_pulse(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
